// File: rtl/sdram_arbiter_if.sv
// Bundles the write/read request handshakes and the SDRAM controller command bus
// that sdram_arbiter sits between. The master modport is the arbiter's view.
interface sdram_arbiter_if #(
  parameter int ADDR_WIDTH = 24
);
  logic                  i_wr_req;
  logic [ADDR_WIDTH-1:0] i_wr_addr;
  logic [ADDR_WIDTH-1:0] i_wr_count;
  logic                  o_wr_gnt;
  logic                  o_wr_done;
  logic                  i_rd_req;
  logic [ADDR_WIDTH-1:0] i_rd_addr;
  logic [ADDR_WIDTH-1:0] i_rd_count;
  logic                  o_rd_gnt;
  logic                  o_rd_done;
  logic [1:0]            o_cmd;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [ADDR_WIDTH-1:0] o_count;
  logic                  i_busy;
  logic [1:0]            o_err;

  modport master (
    input  i_wr_req, i_wr_addr, i_wr_count,
    input  i_rd_req, i_rd_addr, i_rd_count,
    input  i_busy,
    output o_wr_gnt, o_wr_done, o_rd_gnt, o_rd_done,
    output o_cmd, o_addr, o_count, o_err
  );

  modport slave (
    output i_wr_req, i_wr_addr, i_wr_count,
    output i_rd_req, i_rd_addr, i_rd_count,
    output i_busy,
    input  o_wr_gnt, o_wr_done, o_rd_gnt, o_rd_done,
    input  o_cmd, o_addr, o_count, o_err
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller between a write (FIFO drain) and a read (host readout)
// requester, and interleaves periodic auto-refresh. All outputs are registered.
module sdram_arbiter #(
  parameter int ADDR_WIDTH      = 24,
  parameter int REFRESH_PERIOD  = 780,
  parameter int REF_MAX_PENDING = 8,
  parameter int WR_STREAK       = 4,
  parameter int ACK_TIMEOUT     = 15
) (
  input logic             i_clk,
  input logic             i_rst_n,
  sdram_arbiter_if.master bus
);
  localparam int TMR_W  = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int PEND_W = $clog2(REF_MAX_PENDING + 1);
  localparam int STRK_W = $clog2(WR_STREAK + 1);
  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(REFRESH_PERIOD - 1);
  localparam logic [PEND_W-1:0] PEND_MAX   = PEND_W'(REF_MAX_PENDING);
  localparam logic [STRK_W-1:0] STRK_MAX   = STRK_W'(WR_STREAK);
  localparam logic [ACK_W-1:0]  ACK_MAX    = ACK_W'(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACK, RUN} state_e;
  typedef enum logic [1:0] {CMD_NOP = 2'b00, CMD_WRITE = 2'b01,
                            CMD_READ = 2'b10, CMD_REFRESH = 2'b11} cmd_e;
  typedef enum logic [1:0] {OP_REF, OP_WR, OP_RD} op_e;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  cmd_e                  cmd_q, cmd_d;
  logic [TMR_W-1:0]      ref_timer_q, ref_timer_d;
  logic [PEND_W-1:0]     pending_q, pending_d;
  logic [STRK_W-1:0]     streak_q, streak_d;
  logic [ACK_W-1:0]      ack_cnt_q, ack_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  wr_gnt_q, wr_gnt_d, wr_done_q, wr_done_d;
  logic                  rd_gnt_q, rd_gnt_d, rd_done_q, rd_done_d;
  logic [1:0]            err_q, err_d;

  logic tick, ref_issue, wr_ok, rd_ok;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    cmd_d     = CMD_NOP;
    pending_d = pending_q;
    streak_d  = streak_q;
    ack_cnt_d = ack_cnt_q;
    addr_d    = addr_q;
    count_d   = count_q;
    wr_gnt_d  = 1'b0;
    wr_done_d = 1'b0;
    rd_gnt_d  = 1'b0;
    rd_done_d = 1'b0;
    err_d     = err_q;
    ref_issue = 1'b0;

    tick        = (ref_timer_q == '0);
    ref_timer_d = tick ? TMR_RELOAD : ref_timer_q - TMR_W'(1);

    // A zero-count grant leaves us in IDLE while the requester still holds req for one cycle.
    wr_ok = bus.i_wr_req && !wr_gnt_q;
    rd_ok = bus.i_rd_req && !rd_gnt_q;

    unique case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          ref_issue = 1'b1;
          cmd_d     = CMD_REFRESH;
          addr_d    = '0;
          count_d   = '0;
          op_d      = OP_REF;
          ack_cnt_d = '0;
          state_d   = ACK;
        end else if (wr_ok && !(streak_q == STRK_MAX && rd_ok)) begin
          wr_gnt_d = 1'b1;
          if (!bus.i_rd_req)           streak_d = '0;
          else if (streak_q != STRK_MAX) streak_d = streak_q + STRK_W'(1);
          if (bus.i_wr_count == '0) begin
            wr_done_d = 1'b1;
          end else begin
            cmd_d     = CMD_WRITE;
            addr_d    = bus.i_wr_addr;
            count_d   = bus.i_wr_count;
            op_d      = OP_WR;
            ack_cnt_d = '0;
            state_d   = ACK;
          end
        end else if (rd_ok) begin
          rd_gnt_d = 1'b1;
          streak_d = '0;
          if (bus.i_rd_count == '0) begin
            rd_done_d = 1'b1;
          end else begin
            cmd_d     = CMD_READ;
            addr_d    = bus.i_rd_addr;
            count_d   = bus.i_rd_count;
            op_d      = OP_RD;
            ack_cnt_d = '0;
            state_d   = ACK;
          end
        end
      end
      ACK: begin
        if (bus.i_busy) begin
          state_d = RUN;
        end else if (ack_cnt_q == ACK_MAX) begin
          err_d[1]  = 1'b1;
          wr_done_d = (op_q == OP_WR);
          rd_done_d = (op_q == OP_RD);
          state_d   = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      RUN: begin
        if (!bus.i_busy) begin
          wr_done_d = (op_q == OP_WR);
          rd_done_d = (op_q == OP_RD);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A tick landing on a refresh issue cancels out; a tick with the queue full is lost.
    unique case ({tick, ref_issue})
      2'b10: begin
        if (pending_q == PEND_MAX) err_d[0] = 1'b1;
        else                       pending_d = pending_q + PEND_W'(1);
      end
      2'b01:   pending_d = pending_q - PEND_W'(1);
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_REF;
      cmd_q       <= CMD_NOP;
      ref_timer_q <= TMR_RELOAD;
      pending_q   <= '0;
      streak_q    <= '0;
      ack_cnt_q   <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      wr_gnt_q    <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_gnt_q    <= 1'b0;
      rd_done_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cmd_q       <= cmd_d;
      ref_timer_q <= ref_timer_d;
      pending_q   <= pending_d;
      streak_q    <= streak_d;
      ack_cnt_q   <= ack_cnt_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      wr_gnt_q    <= wr_gnt_d;
      wr_done_q   <= wr_done_d;
      rd_gnt_q    <= rd_gnt_d;
      rd_done_q   <= rd_done_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_cmd     = cmd_q;
  assign bus.o_addr    = addr_q;
  assign bus.o_count   = count_q;
  assign bus.o_wr_gnt  = wr_gnt_q;
  assign bus.o_wr_done = wr_done_q;
  assign bus.o_rd_gnt  = rd_gnt_q;
  assign bus.o_rd_done = rd_done_q;
  assign bus.o_err     = err_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a simple controller model answers commands with
// a busy window; cycle numbers count rising edges since reset release.
module tb_sdram_arbiter;
  localparam int AW = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  sdram_arbiter #(
    .ADDR_WIDTH(AW), .REFRESH_PERIOD(780), .REF_MAX_PENDING(8),
    .WR_STREAK(4), .ACK_TIMEOUT(15)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rel = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc - rel);
    end
  endtask

  // Controller model: busy rises busy_dly cycles after a command, stays high busy_len cycles.
  logic auto_busy = 1'b0;
  logic busy_auto = 1'b0;
  logic busy_man  = 1'b0;
  int   busy_dly  = 1;
  int   busy_len  = 2;
  int   sched     = 0;
  int   hold      = 0;

  assign bus.i_busy = auto_busy ? busy_auto : busy_man;

  always @(posedge clk) begin
    #1;
    if (!auto_busy) begin
      sched = 0;
      hold = 0;
      busy_auto = 1'b0;
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) busy_auto = 1'b0;
    end else if (sched > 0) begin
      sched--;
      if (sched == 0) begin
        busy_auto = 1'b1;
        hold = busy_len;
      end
    end else if (bus.o_cmd != 2'b00) begin
      sched = busy_dly;
    end
  end

  int wr_gnt_n = 0, wr_done_n = 0, rd_gnt_n = 0, rd_done_n = 0, ref_n = 0;
  always @(posedge clk) begin
    #2;
    if (bus.o_wr_gnt)        wr_gnt_n++;
    if (bus.o_wr_done)       wr_done_n++;
    if (bus.o_rd_gnt)        rd_gnt_n++;
    if (bus.o_rd_done)       rd_done_n++;
    if (bus.o_cmd == 2'b11)  ref_n++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    auto_busy = 1'b0;
    busy_man = 1'b0;
    bus.i_wr_req = 1'b0;
    bus.i_rd_req = 1'b0;
    bus.i_wr_addr = '0;
    bus.i_wr_count = '0;
    bus.i_rd_addr = '0;
    bus.i_rd_count = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {30'd0, bus.o_cmd} | {28'd0, bus.o_err, 2'b00} |
          {24'd0, bus.o_wr_gnt, bus.o_wr_done, bus.o_rd_gnt, bus.o_rd_done, 4'd0}, 32'd0);
    check("rst_addr", {8'd0, bus.o_addr} | {8'd0, bus.o_count}, 32'd0);
    rst_n = 1'b1;
    rel = cyc;
  endtask

  task automatic wait_until(input int k);
    while (cyc - rel < k) @(negedge clk);
  endtask

  task automatic wait_cmd(input int budget, output logic [1:0] c, output int at);
    c = 2'b00;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_cmd != 2'b00) begin
        c = bus.o_cmd;
        at = cyc - rel;
        return;
      end
    end
  endtask

  task automatic wait_wr_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_wr_done) begin
        at = cyc - rel;
        return;
      end
    end
  endtask

  task automatic wait_rd_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_rd_done) begin
        at = cyc - rel;
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] c;
    int at, at2, snap, snap2;
    int got[$];
    int exp_order[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

    // Idle refresh cadence: first REFRESH at edge 781, next at 1561; no grants.
    do_reset();
    auto_busy = 1'b1; busy_dly = 1; busy_len = 2;
    snap = wr_gnt_n + wr_done_n + rd_gnt_n + rd_done_n;
    wait_cmd(800, c, at);
    check("ref1_cmd", c, 2'b11);
    check("ref1_at", at, 781);
    @(negedge clk);
    check("ref1_one_cycle", bus.o_cmd, 2'b00);
    wait_cmd(900, c, at);
    check("ref2_cmd", c, 2'b11);
    check("ref2_at", at, 1561);
    check("ref_no_pulses", wr_gnt_n + wr_done_n + rd_gnt_n + rd_done_n - snap, 0);
    check("ref_err", bus.o_err, 2'b00);

    // Long write: command one cycle after req, done one cycle after busy falls.
    do_reset();
    auto_busy = 1'b1; busy_dly = 3; busy_len = 260;
    wait_until(2);
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 24'h001200; bus.i_wr_count = 24'd256;
    wait_cmd(4, c, at);
    check("wr_cmd", c, 2'b01);
    check("wr_cmd_at", at, 3);
    check("wr_gnt", bus.o_wr_gnt, 1'b1);
    check("wr_addr", bus.o_addr, 24'h001200);
    check("wr_count", bus.o_count, 24'd256);
    bus.i_wr_req = 1'b0;
    @(negedge clk);
    check("wr_cmd_nop", bus.o_cmd, 2'b00);
    check("wr_addr_hold", bus.o_addr, 24'h001200);
    wait_wr_done(400, at2);
    check("wr_done_at", at2, at + 264);

    // Both requesters held: four writes, then the waiting read gets in.
    do_reset();
    auto_busy = 1'b1; busy_dly = 1; busy_len = 2;
    bus.i_wr_addr = 24'h000100; bus.i_wr_count = 24'd8;
    bus.i_rd_addr = 24'h000200; bus.i_rd_count = 24'd8;
    bus.i_wr_req = 1'b1; bus.i_rd_req = 1'b1;
    for (int i = 0; i < 300 && got.size() < 10; i++) begin
      @(negedge clk);
      if (bus.o_wr_gnt) got.push_back(1);
      if (bus.o_rd_gnt) got.push_back(2);
    end
    bus.i_wr_req = 1'b0; bus.i_rd_req = 1'b0;
    check("streak_n", got.size(), 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("streak_%0d", i), (i < got.size()) ? got[i] : 0, exp_order[i]);
    repeat (20) @(negedge clk);

    // Write request seen in the cycle refresh becomes pending: refresh goes first.
    do_reset();
    auto_busy = 1'b1; busy_dly = 1; busy_len = 2;
    wait_until(780);
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 24'h00ABCD; bus.i_wr_count = 24'd8;
    wait_cmd(5, c, at);
    check("coin_ref_cmd", c, 2'b11);
    check("coin_ref_at", at, 781);
    check("coin_no_wr_gnt", bus.o_wr_gnt, 1'b0);
    wait_cmd(20, c, at);
    check("coin_wr_cmd", c, 2'b01);
    check("coin_wr_at", at, 786);
    check("coin_wr_gnt", bus.o_wr_gnt, 1'b1);
    bus.i_wr_req = 1'b0;
    repeat (20) @(negedge clk);

    // Controller stuck busy across nine ticks: overrun flagged, then 8 refreshes drain.
    do_reset();
    wait_until(2);
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 24'h000040; bus.i_wr_count = 24'd16;
    wait_cmd(4, c, at);
    check("sat_wr_cmd", c, 2'b01);
    bus.i_wr_req = 1'b0;
    busy_man = 1'b1;
    snap = ref_n;
    wait_until(7000);
    check("sat_err_8_ticks", bus.o_err, 2'b00);
    wait_until(7100);
    check("sat_err_9_ticks", bus.o_err, 2'b01);
    check("sat_no_ref_busy", ref_n - snap, 0);
    busy_man = 1'b0;
    busy_dly = 1; busy_len = 2; auto_busy = 1'b1;
    @(negedge clk);
    check("sat_wr_done", bus.o_wr_done, 1'b1);
    snap2 = ref_n;
    wait_until(7700);
    check("sat_ref_drain", ref_n - snap2, 8);
    check("sat_err_sticky", bus.o_err, 2'b01);

    // Zero-count read completes in place; then a read the controller never takes.
    do_reset();
    wait_until(2);
    snap = wr_done_n;
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 24'h000300; bus.i_rd_count = 24'd0;
    @(negedge clk);
    check("zero_gnt", bus.o_rd_gnt, 1'b1);
    check("zero_done", bus.o_rd_done, 1'b1);
    check("zero_cmd_nop", bus.o_cmd, 2'b00);
    check("zero_addr_hold", bus.o_addr, 24'h0);
    bus.i_rd_req = 1'b0;
    @(negedge clk);
    check("zero_no_regrant", {bus.o_rd_gnt, bus.o_rd_done}, 2'b00);
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 24'h000500; bus.i_rd_count = 24'd4;
    wait_cmd(4, c, at);
    check("to_rd_cmd", c, 2'b10);
    check("to_rd_at", at, 5);
    check("to_rd_addr", bus.o_addr, 24'h000500);
    check("to_rd_count", bus.o_count, 24'd4);
    bus.i_rd_req = 1'b0;
    wait_rd_done(40, at2);
    check("to_rd_done_at", at2, at + 16);
    check("to_err", bus.o_err, 2'b10);
    check("to_no_wr_done", wr_done_n - snap, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
